// File: rtl/mm_write_arbiter.sv
// Purpose: round-robin arbiter sharing the single matrix-memory write port among clients_p block writers.
// Latency: accept T, write strobe T+1, done pulse one cycle after memory ready is seen (T+3 at best).
// Backpressure: one write in flight; req_ready_o stays low while busy or while memory is not ready.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_v_i / req_ready_o     per-client request handshake (ready is one-hot on the round-robin winner)
//   req_addr_x_i/_y_i/data_i  per-client 4x4 block address and cell mask
//   done_o                    per-client one-cycle completion pulse
//   busy_o                    high whenever a write is being processed
//   mm_write_*_o              memory write address, mask and one-cycle strobe
//   mm_is_ready_i             memory idle / previous write finished
module mm_write_arbiter #(
  parameter int width_p   = 16,
  parameter int height_p  = 32,
  parameter int clients_p = 3   // must be >= 2; index 0 is the commit executor
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic [clients_p-1:0]                          req_v_i,
  output logic [clients_p-1:0]                          req_ready_o,
  input  logic [clients_p-1:0][$clog2(width_p)-1:0]     req_addr_x_i,
  input  logic [clients_p-1:0][$clog2(height_p)-1:0]    req_addr_y_i,
  input  logic [clients_p-1:0][3:0][3:0]                req_data_i,
  output logic [clients_p-1:0]                          done_o,
  output logic                                          busy_o,
  output logic [$clog2(width_p)-1:0]                    mm_write_addr_x_o,
  output logic [$clog2(height_p)-1:0]                   mm_write_addr_y_o,
  output logic [3:0][3:0]                               mm_write_data_o,
  output logic                                          mm_write_v_o,
  input  logic                                          mm_is_ready_i
);

  localparam int x_w   = $clog2(width_p);
  localparam int y_w   = $clog2(height_p);
  localparam int ptr_w = $clog2(clients_p);

  // Client count at one extra bit so the wrap compare never truncates.
  localparam logic [ptr_w:0] clients_c = (ptr_w+1)'(clients_p);

  typedef enum logic [1:0] {
    eIDLE,
    eIssue,
    eWait,
    eDone
  } state_e;

  state_e                  state_q, state_d;
  logic [ptr_w-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ptr_w-1:0]        owner_q, owner_d;
  logic [x_w-1:0]          hold_x_q, hold_x_d;
  logic [y_w-1:0]          hold_y_q, hold_y_d;
  logic [3:0][3:0]         hold_data_q, hold_data_d;

  // Round-robin scan support.
  logic [clients_p-1:0][ptr_w-1:0] scan_idx;
  logic [ptr_w:0]                  scan_sum;
  logic                            win_found;
  logic [ptr_w-1:0]                win_idx;
  logic [clients_p-1:0]            win_oh;

  // scan_idx[k] is the client checked at priority position k: (rr_ptr + k) mod clients_p.
  // The wrap is an explicit subtract so non-power-of-two client counts rotate correctly.
  always_comb begin
    scan_idx = '0;
    scan_sum = '0;
    for (int k = 0; k < clients_p; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ptr_w+1)'(k);
      if (scan_sum >= clients_c) begin
        scan_sum = scan_sum - clients_c;
      end
      scan_idx[k] = scan_sum[ptr_w-1:0];
    end
  end

  // First requesting client in priority order wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < clients_p; k++) begin
      for (int i = 0; i < clients_p; i++) begin
        if (!win_found && req_v_i[i] && (scan_idx[k] == ptr_w'(i))) begin
          win_found = 1'b1;
          win_idx   = ptr_w'(i);
        end
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < clients_p; i++) begin
      win_oh[i] = win_found && (win_idx == ptr_w'(i));
    end
  end

  // Next-state and outputs.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    hold_x_d     = hold_x_q;
    hold_y_d     = hold_y_q;
    hold_data_d  = hold_data_q;
    req_ready_o  = '0;
    done_o       = '0;
    mm_write_v_o = 1'b0;

    case (state_q)
      eIDLE: begin
        // Payload is only sampled on the accept cycle; until then the
        // client owns it and may change or withdraw it freely.
        if (mm_is_ready_i && win_found) begin
          req_ready_o = win_oh;
          owner_d     = win_idx;
          hold_x_d    = req_addr_x_i[win_idx];
          hold_y_d    = req_addr_y_i[win_idx];
          hold_data_d = req_data_i[win_idx];
          state_d     = eIssue;
        end
      end

      eIssue: begin
        // Memory readiness is deliberately ignored here: a ready level left
        // over from before the strobe must not complete this write.
        mm_write_v_o = 1'b1;
        state_d      = eWait;
      end

      eWait: begin
        if (mm_is_ready_i) begin
          state_d = eDone;
        end
      end

      eDone: begin
        for (int i = 0; i < clients_p; i++) begin
          done_o[i] = (owner_q == ptr_w'(i));
        end
        // The finished client drops to lowest priority.
        rr_ptr_d = (owner_q == ptr_w'(clients_p - 1)) ? '0 : owner_q + 1'b1;
        state_d  = eIDLE;
      end

      default: begin
        state_d = eIDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= eIDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      hold_x_q    <= '0;
      hold_y_q    <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      hold_x_q    <= hold_x_d;
      hold_y_q    <= hold_y_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Holding registers drive the port directly, so the address and mask stay
  // stable from the strobe until the done pulse.
  assign mm_write_addr_x_o = hold_x_q;
  assign mm_write_addr_y_o = hold_y_q;
  assign mm_write_data_o   = hold_data_q;
  assign busy_o            = (state_q != eIDLE);

endmodule

// File: tb/tb_mm_write_arbiter.sv
module tb_mm_write_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_i;
  logic [N-1:0]          req_v;
  logic [N-1:0]          req_ready;
  logic [N-1:0][3:0]     req_x;
  logic [N-1:0][4:0]     req_y;
  logic [N-1:0][3:0][3:0] req_d;
  logic [N-1:0]          done;
  logic                  busy;
  logic [3:0]            wx;
  logic [4:0]            wy;
  logic [3:0][3:0]       wd;
  logic                  wv;
  logic                  mm_rdy;

  mm_write_arbiter #(.width_p(16), .height_p(32), .clients_p(N)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .req_v_i           (req_v),
    .req_ready_o       (req_ready),
    .req_addr_x_i      (req_x),
    .req_addr_y_i      (req_y),
    .req_data_i        (req_d),
    .done_o            (done),
    .busy_o            (busy),
    .mm_write_addr_x_o (wx),
    .mm_write_addr_y_o (wy),
    .mm_write_data_o   (wd),
    .mm_write_v_o      (wv),
    .mm_is_ready_i     (mm_rdy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One write in flight: accepted, strobed one cycle later, completed one
  // cycle after memory ready is observed at least two cycles after accept.
  bit          m_busy = 0;
  int          m_owner = 0;
  int          m_rr = 0;
  int          m_age = 0;     // cycles since accept for the current cycle
  bit          m_rdy_seen = 0;
  logic [3:0]  m_x = '0;
  logic [4:0]  m_y = '0;
  logic [15:0] m_d = '0;
  bit          m_gnt_last = 0;
  int          m_gnt_who = 0;

  function automatic int m_winner();
    int w = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (w < 0 && req_v[i]) w = i;
    end
    return w;
  endfunction

  always @(posedge clk) begin : model
    int w;
    if (reset_i) begin
      m_busy = 0; m_owner = 0; m_rr = 0; m_age = 0; m_rdy_seen = 0;
      m_x = '0; m_y = '0; m_d = '0; m_gnt_last = 0;
    end else begin
      m_gnt_last = 0;
      if (!m_busy) begin
        w = m_winner();
        if (w >= 0 && mm_rdy) begin
          m_busy = 1; m_owner = w; m_age = 1; m_rdy_seen = 0;
          m_x = req_x[w]; m_y = req_y[w]; m_d = req_d[w];
          m_gnt_last = 1; m_gnt_who = w;
        end
      end else if (m_rdy_seen) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % N;
      end else begin
        if (m_age >= 2 && mm_rdy) m_rdy_seen = 1;
        m_age++;
      end
    end
  end

  // ---------------- event logs of DUT activity ----------------
  int acc_cyc_q[$], acc_who_q[$], strobe_cyc_q[$], done_cyc_q[$], done_val_q[$];
  logic [3:0]  s_x;
  logic [4:0]  s_y;
  logic [15:0] s_d;

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    acc_cyc_q.delete(); acc_who_q.delete(); strobe_cyc_q.delete();
    done_cyc_q.delete(); done_val_q.delete();
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    int w;
    logic [N-1:0] er, ed, acc;
    if (chk_en) begin
      w = m_winner();
      er = '0;
      if (!m_busy && mm_rdy && w >= 0) er[w] = 1'b1;
      ed = '0;
      if (m_busy && m_rdy_seen) ed[m_owner] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("mm_write_v", 64'(wv), 64'(m_busy && m_age == 1));
      chk("done", 64'(done), 64'(ed));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("mm_write_x", 64'(wx), 64'(m_x));
      chk("mm_write_y", 64'(wy), 64'(m_y));
      chk("mm_write_data", 64'(wd), 64'(m_d));
      acc = req_v & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc_cyc_q.push_back(cyc);
          acc_who_q.push_back(i);
        end
      end
      if (wv) begin
        strobe_cyc_q.push_back(cyc);
        s_x = wx; s_y = wy; s_d = wd;
      end
      if (done != '0) begin
        done_cyc_q.push_back(cyc);
        done_val_q.push_back(int'(done));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_i = 1'b1;
    req_v = '0;
    mm_rdy = 1'b1;
    tick();
    chk_en = 1;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; req_v = '0; mm_rdy = 1'b1;
    req_x = '0; req_y = '0; req_d = '0;

    // ---- reset state ----
    reset_dut();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_v", 64'(wv), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_x", 64'(wx), 64'd0);
    chk("rst_y", 64'(wy), 64'd0);
    chk("rst_data", 64'(wd), 64'd0);

    // ---- single request, client 0, memory busy 3 cycles after strobe ----
    clear_logs();
    req_x[0] = 4'd5; req_y[0] = 5'd12; req_d[0] = 16'h0660;
    req_v = 3'b001;
    tick();                       // accept
    req_v = '0;
    tick();                       // strobe
    mm_rdy = 1'b0;
    repeat (3) tick();            // waiting
    mm_rdy = 1'b1;
    repeat (4) tick();            // ready seen, done, idle
    chk("t1_accepts", 64'(acc_cyc_q.size()), 64'd1);
    chk("t1_who", 64'(qget(acc_who_q, 0)), 64'd0);
    chk("t1_strobes", 64'(strobe_cyc_q.size()), 64'd1);
    chk("t1_strobe_lat", 64'(qget(strobe_cyc_q, 0) - qget(acc_cyc_q, 0)), 64'd1);
    chk("t1_x", 64'(s_x), 64'd5);
    chk("t1_y", 64'(s_y), 64'd12);
    chk("t1_data", 64'(s_d), 64'h0660);
    chk("t1_done_lat", 64'(qget(done_cyc_q, 0) - qget(acc_cyc_q, 0)), 64'd6);
    chk("t1_done_val", 64'(qget(done_val_q, 0)), 64'b001);

    // ---- all clients requesting continuously ----
    reset_dut();
    clear_logs();
    for (int k = 0; k < N; k++) begin
      req_x[k] = 4'(k + 1); req_y[k] = 5'(k + 7); req_d[k] = 16'(16'h1111 * (k + 1));
    end
    req_v = 3'b111;
    repeat (24) tick();
    req_v = '0;
    repeat (4) tick();
    chk("t2_accepts", 64'(acc_cyc_q.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_order", 64'(qget(acc_who_q, i)), 64'(i % N));
      chk("t2_done_val", 64'(qget(done_val_q, i)), 64'(1 << (i % N)));
    end
    for (int i = 1; i < 6; i++) begin
      chk("t2_spacing", 64'(qget(acc_cyc_q, i) - qget(acc_cyc_q, i - 1)), 64'd4);
    end
    chk("t2_dones", 64'(done_cyc_q.size()), 64'd6);

    // ---- memory not ready while idle, client 2 requesting ----
    reset_dut();
    clear_logs();
    req_x[2] = 4'd3; req_y[2] = 5'd30; req_d[2] = 16'hF00F;
    mm_rdy = 1'b0;
    req_v = 3'b100;
    repeat (5) tick();
    chk("t3_no_accept", 64'(acc_cyc_q.size()), 64'd0);
    chk("t3_no_strobe", 64'(strobe_cyc_q.size()), 64'd0);
    mm_rdy = 1'b1;
    tick();
    req_v = '0;
    repeat (5) tick();
    chk("t3_who", 64'(qget(acc_who_q, 0)), 64'd2);
    chk("t3_strobe_lat", 64'(qget(strobe_cyc_q, 0) - qget(acc_cyc_q, 0)), 64'd1);

    // ---- stale ready held high ----
    reset_dut();
    clear_logs();
    req_x[1] = 4'd9; req_y[1] = 5'd17; req_d[1] = 16'hA5A5;
    req_v = 3'b010;
    tick();
    req_v = '0;
    repeat (6) tick();
    chk("t4_strobes", 64'(strobe_cyc_q.size()), 64'd1);
    chk("t4_strobe_lat", 64'(qget(strobe_cyc_q, 0) - qget(acc_cyc_q, 0)), 64'd1);
    chk("t4_done_lat", 64'(qget(done_cyc_q, 0) - qget(acc_cyc_q, 0)), 64'd3);
    chk("t4_done_val", 64'(qget(done_val_q, 0)), 64'b010);

    // ---- reset during wait while client 1 owns the port ----
    reset_dut();
    req_v = 3'b001;
    tick();
    req_v = '0;
    repeat (3) tick();            // strobe, wait, done -> rr now favours client 1
    req_v = 3'b010;
    tick();                       // client 1 accepted
    req_v = '0;
    tick();                       // strobe
    mm_rdy = 1'b0;
    tick();                       // waiting
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_v", 64'(wv), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_x", 64'(wx), 64'd0);
    chk("t5_data", 64'(wd), 64'd0);
    clear_logs();
    mm_rdy = 1'b1;
    repeat (3) tick();
    chk("t5_no_done", 64'(done_cyc_q.size()), 64'd0);
    req_v = 3'b011;
    tick();
    chk("t5_rr_reset", 64'(qget(acc_who_q, 0)), 64'd0);
    req_v = '0;
    repeat (4) tick();

    // ---- withdrawal while another client owns the port ----
    reset_dut();
    clear_logs();
    req_v = 3'b001;
    tick();                       // client 0 accepted
    req_v = 3'b010;
    repeat (2) tick();            // client 1 requests while busy
    req_v = 3'b000;               // withdraws in the done cycle
    repeat (4) tick();
    chk("t6_accepts", 64'(acc_cyc_q.size()), 64'd1);
    chk("t6_dones", 64'(done_cyc_q.size()), 64'd1);
    chk("t6_done_val", 64'(qget(done_val_q, 0)), 64'b001);
    chk("t6_idle", 64'(busy), 64'd0);

    // ---- randomized traffic against the model ----
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      reset_i = ($urandom_range(0, 299) == 0);
      mm_rdy  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (req_v[k]) begin
          if (m_gnt_last && m_gnt_who == k) req_v[k] = 1'b0;
          else if ($urandom_range(0, 15) == 0) req_v[k] = 1'b0;
        end
        if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          req_v[k] = 1'b1;
          req_x[k] = 4'($urandom);
          req_y[k] = 5'($urandom);
          req_d[k] = 16'($urandom);
        end
      end
      tick();
    end
    reset_i = 1'b0;
    req_v = '0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
